// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : go / data / data_ready handshake between the UART receiver and
//            its consumer in the RAM/IO block.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       go;
    logic [7:0] data;
    logic       data_ready;

    modport master (
        output go,
        input  data,
        input  data_ready
    );

    modport slave (
        input  go,
        output data,
        output data_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, oversampled by the system clock, holding each
//            byte under a go / data_ready handshake. Define UART_RX_PARITY_EN
//            for 8E1 framing with a parity check.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLOCK_FREQUENCY_HZ = 20_250_000,
    parameter int BAUD_RATE          = 9600
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic rx,
    uart_rx_if.slave  bus
);
    localparam int c_BIT_TICKS = CLOCK_FREQUENCY_HZ / BAUD_RATE;
    localparam int c_TICK_W    = $clog2(c_BIT_TICKS) + 1;

    localparam logic [c_TICK_W-1:0] c_BIT_LAST  = c_TICK_W'(c_BIT_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(c_BIT_TICKS / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_WAIT_START = 3'd1;
    localparam logic [2:0] c_S_START      = 3'd2;
    localparam logic [2:0] c_S_DATA       = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY     = 3'd4;
`endif
    localparam logic [2:0] c_S_STOP       = 3'd5;
    localparam logic [2:0] c_S_WAIT_HIGH  = 3'd6;
    localparam logic [2:0] c_S_DONE       = 3'd7;

    logic                r_rx_meta;
    logic                r_rxs;
    logic [2:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_bit;
    logic [7:0]          r_data;
    logic                r_ready;

    logic [2:0]          w_state_nxt;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_data_nxt;
    logic                w_ready_nxt;
    logic                w_frame_ok;

`ifdef UART_RX_PARITY_EN
    logic                r_par_err;
    logic                w_par_err_nxt;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_frame_ok = r_rxs && !r_par_err;
`else
    assign w_frame_ok = r_rxs;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready;
`ifdef UART_RX_PARITY_EN
        w_par_err_nxt = r_par_err;
`endif
        case (r_state)
            c_S_IDLE: begin
                if (bus.go) begin
                    w_state_nxt = c_S_WAIT_START;
                end
            end
            c_S_WAIT_START: begin
                if (!r_rxs) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                // Start bit must still be low at its midpoint, else it was a glitch
                if (r_tick == c_HALF_LAST) begin
                    if (!r_rxs) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = c_S_DATA;
                    end else begin
                        w_state_nxt = c_S_WAIT_START;
                    end
                end else begin
                    w_tick_nxt = r_tick + c_TICK_ONE;
                end
            end
            c_S_DATA: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt        = '0;
                    w_data_nxt[r_bit] = r_rxs;
                    w_bit_nxt         = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = c_S_PARITY;
`else
                        w_state_nxt = c_S_STOP;
`endif
                    end
                end else begin
                    w_tick_nxt = r_tick + c_TICK_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            c_S_PARITY: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt    = '0;
                    w_par_err_nxt = ^{r_data, r_rxs};
                    w_state_nxt   = c_S_STOP;
                end else begin
                    w_tick_nxt = r_tick + c_TICK_ONE;
                end
            end
`endif
            c_S_STOP: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt = '0;
                    if (w_frame_ok) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = c_S_DONE;
                    end else begin
                        w_state_nxt = c_S_WAIT_HIGH;
                    end
                end else begin
                    w_tick_nxt = r_tick + c_TICK_ONE;
                end
            end
            c_S_WAIT_HIGH: begin
                // A held-low line (break) must release before the next start bit
                if (r_rxs) begin
                    w_state_nxt = c_S_WAIT_START;
                end
            end
            c_S_DONE: begin
                if (!bus.go) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_nxt;
        end
    end
`endif

    assign bus.data       = r_data;
    assign bus.data_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a byte scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;
    localparam int c_BIT = 10;
`ifdef UART_RX_PARITY_EN
    localparam int c_LAT_NOM = 108;
`else
    localparam int c_LAT_NOM = 98;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rx;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_FREQUENCY_HZ(1_000_000),
        .BAUD_RATE         (100_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Drives one frame from a falling clock edge; good frames enter the scoreboard
    task automatic send_frame(input logic [7:0] b, input bit par_bad, input int stop_low);
        if (!par_bad && stop_low == 0) exp_q.push_back(b);
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_bad;
        repeat (c_BIT) @(negedge clk);
`endif
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic recv(input int max_cycles, output bit got, output logic [7:0] d, output int lat);
        got = 1'b0;
        d   = '0;
        lat = 0;
        for (int n = 1; n <= max_cycles && !got; n++) begin
            @(negedge clk);
            if (bus.data_ready === 1'b1) begin
                got = 1'b1;
                d   = bus.data;
                lat = n;
            end
        end
    endtask

    task automatic ack_pulse;
        bus.go = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
    endtask

    task automatic test_reset;
        bit got; logic [7:0] d; int lat;
        rst = 1'b1; rx = 1'b1; bus.go = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.data); end
        checks++;
        if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.data_ready); end
        bus.go = 1'b1;
        recv(200, got, d, lat);
        checks++;
        if (got !== 1'b0) begin errors++; $display("FAIL reset_idle: data_ready=%b with data %h, expected no byte", got, d); end
    endtask

    task automatic test_single;
        bit got; logic [7:0] d; logic [7:0] e; int lat; bit hold_bad;
        fork
            send_frame(8'h55, 1'b0, 0);
            recv(130, got, d, lat);
        join
        checks++;
        if (got !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL single_ready: got data_ready=%b expected 1", got);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL single_data: got %h expected %h", d, e); end
            checks++;
            if (lat < c_LAT_NOM - 2 || lat > c_LAT_NOM + 2)
                begin errors++; $display("FAIL single_latency: got %0d cycles expected %0d +/-2", lat, c_LAT_NOM); end
        end
        hold_bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.data_ready !== 1'b1 || bus.data !== 8'h55) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin errors++; $display("FAIL single_hold: got ready=%b data=%h expected 1/55", bus.data_ready, bus.data); end
        ack_pulse();
        checks++;
        if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL single_ack: got ready=%b expected 0", bus.data_ready); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit got; logic [7:0] d; logic [7:0] e; int lat;
        fork
            begin
                send_frame(8'hA3, 1'b0, 0);
                send_frame(8'h0F, 1'b0, 0);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    recv(130, got, d, lat);
                    checks++;
                    if (got !== 1'b1 || exp_q.size() == 0) begin
                        errors++; $display("FAIL b2b_ready%0d: got data_ready=%b expected 1", k, got);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (d !== e) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, d, e); end
                        ack_pulse();
                    end
                end
            end
        join
        repeat (5) @(negedge clk);
    endtask

    task automatic test_glitch;
        bit got; logic [7:0] d; logic [7:0] e; int lat;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        recv(120, got, d, lat);
        checks++;
        if (got !== 1'b0) begin errors++; $display("FAIL glitch_drop: got data_ready=%b data %h expected 0", got, d); end
        fork
            send_frame(8'h3C, 1'b0, 0);
            recv(130, got, d, lat);
        join
        checks++;
        if (got !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL glitch_ready: got data_ready=%b expected 1", got);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL glitch_data: got %h expected %h", d, e); end
            ack_pulse();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_framing;
        bit got; logic [7:0] d; logic [7:0] e; int lat;
        fork
            send_frame(8'h00, 1'b0, 30);
            recv(140, got, d, lat);
        join
        checks++;
        if (got !== 1'b0) begin errors++; $display("FAIL framing_drop: got data_ready=%b data %h expected 0", got, d); end
        repeat (20) @(negedge clk);
        fork
            send_frame(8'h7E, 1'b0, 0);
            recv(130, got, d, lat);
        join
        checks++;
        if (got !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL framing_ready: got data_ready=%b expected 1", got);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL framing_data: got %h expected %h", d, e); end
            ack_pulse();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        bit got; logic [7:0] d; logic [7:0] e; int lat;
        // Start of a 0xFF frame, cut after four data bits
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * c_BIT + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", bus.data_ready); end
        checks++;
        if (bus.data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", bus.data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        fork
            send_frame(8'h81, 1'b0, 0);
            recv(130, got, d, lat);
        join
        checks++;
        if (got !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL midrst_rx_ready: got data_ready=%b expected 1", got);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL midrst_rx_data: got %h expected %h", d, e); end
            ack_pulse();
        end
        repeat (5) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        bit got; logic [7:0] d; int lat;
        fork
            send_frame(8'h81, 1'b1, 0);
            recv(140, got, d, lat);
        join
        checks++;
        if (got !== 1'b0) begin errors++; $display("FAIL parity_drop: got data_ready=%b data %h expected 0", got, d); end
        repeat (5) @(negedge clk);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d bytes left, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
